inst_fetch_queue: RTL and testbench

- Circular instruction buffer between fetch and dual-issue decode in the ppc core.
- Fetch pushes one 64-bit memory word per cycle, i.e. two 32-bit instructions.
- Decode reads the two oldest instructions and pops 0, 1 or 2 per cycle, depending on whether the pair can issue in parallel.
- Provides full/empty back-pressure, clamping and flush for branch/sc redirect.

---
 rtl/ppc_pkg.sv | 17 +
 rtl/iq_storage.sv | 32 +++
 rtl/inst_fetch_queue.sv | 91 +++++++++
 tb/tb_inst_fetch_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ppc_pkg.sv
// Shared ppc core constants: instruction/fetch widths and the decode pop-count encoding.
// The fetch and decode stages use these as well as the instruction queue.
package ppc_pkg;

  localparam int INST_W  = 32;
  localparam int FETCH_W = 64;

  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_ONE  = 2'd1;
  localparam logic [1:0] POP_TWO  = 2'd2;

  // The illegal request 3 is served as a two-entry pop; the error flag is raised by the caller.
  function automatic logic [1:0] clampPop(input logic [1:0] req);
    return (req == 2'd3) ? POP_TWO : req;
  endfunction

endpackage

// File: rtl/iq_storage.sv
// Instruction queue register array: one paired write (even/odd entry) per cycle, two async reads.
// Entries are deliberately left unreset; the owner qualifies reads with its own valid flags.
module iq_storage #(
  parameter int DEPTH = 64,
  parameter int IW    = 32,
  parameter int PW    = 6
) (
  input  logic            clk,
  input  logic            wrEn,
  input  logic [PW-2:0]   wrPair,
  input  logic [0:IW-1]   wrEven,
  input  logic [0:IW-1]   wrOdd,
  input  logic [PW-1:0]   rdAddr0,
  input  logic [PW-1:0]   rdAddr1,
  output logic [0:IW-1]   rdData0,
  output logic [0:IW-1]   rdData1
);

  logic [0:IW-1] mem [DEPTH];

  // Pushes always land on an even/odd pair, so the two write ports never collide.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[{wrPair, 1'b0}] <= wrEven;
      mem[{wrPair, 1'b1}] <= wrOdd;
    end
  end

  assign rdData0 = mem[rdAddr0];
  assign rdData1 = mem[rdAddr1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction buffer between fetch (one 64-bit word per cycle) and dual-issue decode.
// Owns the pointers, occupancy, back-pressure, flush and sticky error flags.
module inst_fetch_queue
  import ppc_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IW    = INST_W,
  parameter int PW    = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push_valid,
  input  logic [0:2*IW-1] push_data,
  output logic            push_ready,
  output logic            head0_valid,
  output logic [0:IW-1]   head0_inst,
  output logic            head1_valid,
  output logic [0:IW-1]   head1_inst,
  input  logic [0:1]      pop_count,
  output logic [0:PW]     count,
  output logic            overflow_err,
  output logic            pop_err
);

  localparam logic [PW:0] PUSH_LIMIT = (PW+1)'(DEPTH - 2);

  logic [PW:0]   head;
  logic [PW:0]   tail;
  logic [PW:0]   occupancy;
  logic [PW:0]   popReq;
  logic [PW:0]   popEff;
  logic          pushAcc;
  logic          pushRefused;
  logic          popBad;
  logic [0:IW-1] rdData0;
  logic [0:IW-1] rdData1;

  // The extra wrap bit on each pointer makes tail - head the exact occupancy, full included.
  assign occupancy   = tail - head;
  assign push_ready  = (occupancy <= PUSH_LIMIT);
  assign pushAcc     = push_valid & push_ready & ~flush;
  assign pushRefused = push_valid & ~push_ready & ~flush;

  assign popReq = (PW+1)'(clampPop(pop_count));
  assign popEff = (popReq > occupancy) ? occupancy : popReq;
  assign popBad = ~flush & ((pop_count == 2'd3) | ((PW+1)'(pop_count) > occupancy));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      overflow_err <= 1'b0;
      pop_err      <= 1'b0;
    end else begin
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        head <= head + popEff;
        if (pushAcc) tail <= tail + (PW+1)'(2);
      end
      if (pushRefused) overflow_err <= 1'b1;
      if (popBad)      pop_err      <= 1'b1;
    end
  end

  iq_storage #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .PW    (PW)
  ) storage (
    .clk     (clk),
    .wrEn    (pushAcc),
    .wrPair  (tail[PW-1:1]),
    .wrEven  (push_data[0:IW-1]),
    .wrOdd   (push_data[IW:2*IW-1]),
    .rdAddr0 (head[PW-1:0]),
    .rdAddr1 (head[PW-1:0] + PW'(1)),
    .rdData0 (rdData0),
    .rdData1 (rdData1)
  );

  // Unwritten storage is never exposed: instruction outputs read as zero while invalid.
  assign count       = occupancy;
  assign head0_valid = (occupancy >= (PW+1)'(1));
  assign head1_valid = (occupancy >= (PW+1)'(2));
  assign head0_inst  = head0_valid ? rdData0 : '0;
  assign head1_inst  = head1_valid ? rdData1 : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the instruction buffer.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic [0:63] push_data;
  logic        push_ready;
  logic        head0_valid;
  logic [0:31] head0_inst;
  logic        head1_valid;
  logic [0:31] head1_inst;
  logic [0:1]  pop_count;
  logic [0:6]  count;
  logic        overflow_err;
  logic        pop_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain FIFO of instructions plus the two sticky flags.
  logic [31:0] modelQ[$];
  logic        modelOvf;
  logic        modelPerr;

  inst_fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .head0_valid  (head0_valid),
    .head0_inst   (head0_inst),
    .head1_valid  (head1_valid),
    .head1_inst   (head1_inst),
    .pop_count    (pop_count),
    .count        (count),
    .overflow_err (overflow_err),
    .pop_err      (pop_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic verifyState(input string tag);
    int n;
    n = modelQ.size();
    checkOutput({tag, ".count"}, 64'(count), 64'(n));
    checkOutput({tag, ".ready"}, 64'(push_ready), 64'(n <= 62));
    checkOutput({tag, ".v0"}, 64'(head0_valid), 64'(n >= 1));
    checkOutput({tag, ".v1"}, 64'(head1_valid), 64'(n >= 2));
    checkOutput({tag, ".ovf"}, 64'(overflow_err), 64'(modelOvf));
    checkOutput({tag, ".perr"}, 64'(pop_err), 64'(modelPerr));
    if (n >= 1) checkOutput({tag, ".inst0"}, 64'(head0_inst), 64'(modelQ[0]));
    if (n >= 2) checkOutput({tag, ".inst1"}, 64'(head1_inst), 64'(modelQ[1]));
  endtask

  // Queue semantics: pops take the oldest entries present before the edge, then the pair is appended.
  task automatic modelStep(input logic pv, input logic [0:63] pd, input int pc, input logic fl);
    int n, req, eff;
    n = modelQ.size();
    if (fl) begin
      modelQ.delete();
      return;
    end
    req = (pc == 3) ? 2 : pc;
    eff = (req > n) ? n : req;
    if (pc == 3 || pc > n) modelPerr = 1'b1;
    if (pv && n > 62) modelOvf = 1'b1;
    for (int i = 0; i < eff; i++) void'(modelQ.pop_front());
    if (pv && n <= 62) begin
      modelQ.push_back(pd[0:31]);
      modelQ.push_back(pd[32:63]);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [0:63] pd, input int pc, input logic fl, input string tag);
    push_valid = pv;
    push_data  = pd;
    pop_count  = 2'(pc);
    flush      = fl;
    modelStep(pv, pd, pc, fl);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    pop_count  = 2'd0;
    flush      = 1'b0;
    verifyState(tag);
  endtask

  // Reset is raised between edges and checked before any edge arrives.
  task automatic pulseReset(input string tag);
    push_valid = 1'b1;
    push_data  = {$urandom, $urandom};
    pop_count  = 2'd1;
    #2;
    rst = 1'b1;
    modelQ.delete();
    modelOvf  = 1'b0;
    modelPerr = 1'b0;
    #1;
    verifyState(tag);
    push_valid = 1'b0;
    pop_count  = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:63] randWord();
    return {$urandom, $urandom};
  endfunction

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    push_valid = 1'b0;
    push_data  = '0;
    pop_count  = 2'd0;
    modelOvf   = 1'b0;
    modelPerr  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    verifyState("reset");

    applyStimulus(1'b0, 64'h0, 0, 1'b0, "idle");

    applyStimulus(1'b1, 64'h7C221A14_38600001, 0, 1'b0, "push1");
    checkOutput("push1.h0const", 64'(head0_inst), 64'h7C221A14);
    checkOutput("push1.h1const", 64'(head1_inst), 64'h38600001);

    for (int i = 0; i < 31; i++) applyStimulus(1'b1, randWord(), 0, 1'b0, "fill");
    checkOutput("full.count", 64'(count), 64'd64);
    checkOutput("full.ready", 64'(push_ready), 64'd0);

    applyStimulus(1'b1, 64'hDEADBEEF_CAFEF00D, 0, 1'b0, "push33");
    checkOutput("push33.ovf", 64'(overflow_err), 64'd1);
    checkOutput("push33.count", 64'(count), 64'd64);
    checkOutput("push33.h0const", 64'(head0_inst), 64'h7C221A14);

    // Full queue refuses a push even while popping that same cycle.
    applyStimulus(1'b1, randWord(), 3, 1'b0, "pop3full");
    checkOutput("pop3full.count", 64'(count), 64'd62);
    checkOutput("pop3full.perr", 64'(pop_err), 64'd1);

    for (int i = 0; i < 26; i++) applyStimulus(1'b0, 64'h0, 2, 1'b0, "drain");
    checkOutput("pre.flush.count", 64'(count), 64'd10);
    applyStimulus(1'b1, randWord(), 1, 1'b1, "flush");
    checkOutput("flush.count", 64'(count), 64'd0);
    checkOutput("flush.ovf", 64'(overflow_err), 64'd1);
    checkOutput("flush.perr", 64'(pop_err), 64'd1);

    pulseReset("rst1");
    applyStimulus(1'b1, randWord(), 0, 1'b0, "c1push");
    applyStimulus(1'b0, 64'h0, 1, 1'b0, "c1pop");
    applyStimulus(1'b0, 64'h0, 2, 1'b0, "c1over");
    checkOutput("c1over.count", 64'(count), 64'd0);
    checkOutput("c1over.perr", 64'(pop_err), 64'd1);
    applyStimulus(1'b1, randWord(), 0, 1'b0, "c1after");

    // Wrap-around: head parked at index 60 with 62 entries, then push+pop2 together.
    pulseReset("rst2");
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, randWord(), 0, 1'b0, "wfill");
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 64'h0, 2, 1'b0, "wpop");
    for (int i = 0; i < 29; i++) applyStimulus(1'b1, randWord(), 0, 1'b0, "wrefill");
    checkOutput("wrap.pre.count", 64'(count), 64'd62);
    applyStimulus(1'b1, 64'hAAAAAAAA_BBBBBBBB, 2, 1'b0, "wrap");
    checkOutput("wrap.count", 64'(count), 64'd62);
    checkOutput("wrap.tailEntry", 64'(modelQ[60]), 64'hAAAAAAAA);
    applyStimulus(1'b0, 64'h0, 1, 1'b0, "wrap.cross");
    while (modelQ.size() > 0) applyStimulus(1'b0, 64'h0, 2, 1'b0, "wrap.drain");

    pulseReset("rst3");
    for (int cyc = 0; cyc < 600; cyc++) begin
      int pc;
      logic pv, fl;
      pv = ($urandom_range(0, 99) < 55);
      pc = int'($urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0) pc = 3;
      fl = ($urandom_range(0, 79) == 0);
      if (cyc == 300) pulseReset("rstMid");
      else applyStimulus(pv, randWord(), pc, fl, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
